pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use interlock, data-memory wait, branch redirect
// and instruction-fetch stall, with a saturating count of cycles in which the PC is held.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// RUN        | normal issue; hazards checked in priority order
// LOAD_STALL | single bubble after a load-use hit; load-use check suppressed
// MEM_WAIT   | MEM stage waiting on data memory; pipeline frozen
// REDIRECT   | branch taken last cycle; fetch of the new target in progress
module pipeline_ctrl #(
    parameter int RegAddrWidth = 5,
    parameter int CntWidth     = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [RegAddrWidth-1:0] id_rs1,
    input  logic [RegAddrWidth-1:0] id_rs2,
    input  logic [RegAddrWidth-1:0] ex_rd,
    input  logic                    ex_mem_read,
    input  logic                    ex_branch_taken,
    input  logic                    mem_access,
    input  logic                    imem_ready,
    input  logic                    dmem_ready,
    input  logic                    clear_count,
    output logic                    pc_en,
    output logic                    if_id_en,
    output logic                    ex_mem_en,
    output logic                    if_id_flush,
    output logic                    id_ex_flush,
    output logic [1:0]              state,
    output logic [CntWidth-1:0]     stall_count
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        REDIRECT   = 2'd3
    } state_t;

    localparam logic [CntWidth-1:0] CntMax = '1;
    localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_next;
    logic [CntWidth-1:0]   r_stall_count;
    logic                  w_load_use;
    logic                  w_dstall;
    logic                  w_pc_en;
    logic                  w_if_id_en;
    logic                  w_ex_mem_en;
    logic                  w_if_id_flush;
    logic                  w_id_ex_flush;

    assign w_load_use = ex_mem_read && (ex_rd != '0) &&
                        ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign w_dstall   = mem_access && !dmem_ready;

    always_comb begin
        w_pc_en       = 1'b1;
        w_if_id_en    = 1'b1;
        w_ex_mem_en   = 1'b1;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_next        = r_state;

        case (r_state)
            RUN, LOAD_STALL: begin
                w_next = RUN;
                if (w_dstall) begin
                    w_pc_en       = 1'b0;
                    w_if_id_en    = 1'b0;
                    w_ex_mem_en   = 1'b0;
                    w_id_ex_flush = 1'b1;
                    w_next        = MEM_WAIT;
                end else if (ex_branch_taken) begin
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                    w_next        = REDIRECT;
                end else if (w_load_use && (r_state == RUN)) begin
                    w_pc_en       = 1'b0;
                    w_if_id_en    = 1'b0;
                    w_id_ex_flush = 1'b1;
                    w_next        = LOAD_STALL;
                end else if (!imem_ready) begin
                    w_pc_en       = 1'b0;
                    w_if_id_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (w_dstall) begin
                    w_pc_en       = 1'b0;
                    w_if_id_en    = 1'b0;
                    w_ex_mem_en   = 1'b0;
                    w_id_ex_flush = 1'b1;
                end else begin
                    w_next = RUN;
                end
            end
            REDIRECT: begin
                if (w_dstall) begin
                    w_pc_en       = 1'b0;
                    w_if_id_en    = 1'b0;
                    w_ex_mem_en   = 1'b0;
                    w_id_ex_flush = 1'b1;
                end else begin
                    w_if_id_flush = 1'b1;
                    w_pc_en       = imem_ready;
                    w_next        = RUN;
                end
            end
            default: w_next = RUN;
        endcase
    end

    // Reset holds the pipeline frozen and bubbled regardless of state.
    always_comb begin
        pc_en       = w_pc_en;
        if_id_en    = w_if_id_en;
        ex_mem_en   = w_ex_mem_en;
        if_id_flush = w_if_id_flush;
        id_ex_flush = w_id_ex_flush;
        if (!reset) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            ex_mem_en   = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= RUN;
            r_stall_count <= '0;
        end else begin
            r_state <= w_next;
            if (clear_count) begin
                r_stall_count <= '0;
            end else if (!w_pc_en && (r_stall_count != CntMax)) begin
                r_stall_count <= r_stall_count + CntOne;
            end
        end
    end

    assign state       = r_state;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: the driver queues hand-computed expectations per cycle,
// a monitor on the falling edge pops and compares them against both counter widths.
module tb_pipeline_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_mem_read, ex_branch_taken, mem_access;
    logic        imem_ready, dmem_ready, clear_count;
    logic        pc_en, if_id_en, ex_mem_en, if_id_flush, id_ex_flush;
    logic [1:0]  state;
    logic [15:0] stall_count;
    logic        pc_en2, if_id_en2, ex_mem_en2, if_id_flush2, id_ex_flush2;
    logic [1:0]  state2;
    logic [1:0]  stall_count2;

    always #5 clock = ~clock;

    pipeline_ctrl dut (
        .clock(clock), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_access(mem_access), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .clear_count(clear_count),
        .pc_en(pc_en), .if_id_en(if_id_en), .ex_mem_en(ex_mem_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .state(state), .stall_count(stall_count)
    );

    pipeline_ctrl #(.RegAddrWidth(5), .CntWidth(2)) dut2 (
        .clock(clock), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_access(mem_access), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .clear_count(clear_count),
        .pc_en(pc_en2), .if_id_en(if_id_en2), .ex_mem_en(ex_mem_en2),
        .if_id_flush(if_id_flush2), .id_ex_flush(id_ex_flush2),
        .state(state2), .stall_count(stall_count2)
    );

    typedef struct {
        string       name;
        logic [4:0]  outs;
        logic [1:0]  st;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Output encodings {pc_en, if_id_en, ex_mem_en, if_id_flush, id_ex_flush}
    localparam logic [4:0] O_DEF = 5'b11100;
    localparam logic [4:0] O_DST = 5'b00001;
    localparam logic [4:0] O_BR  = 5'b11111;
    localparam logic [4:0] O_LU  = 5'b00101;
    localparam logic [4:0] O_IM  = 5'b01110;
    localparam logic [4:0] O_RD  = 5'b11110;
    localparam logic [4:0] O_RST = 5'b00011;

    task automatic drive(input string nm, input logic rst,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic mr, input logic br, input logic ma,
                         input logic ir, input logic dr, input logic clr,
                         input logic [4:0] eo, input logic [1:0] es,
                         input int ec, input int ec2);
        exp_t e;
        @(posedge clock);
        #1;
        reset = rst; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        ex_mem_read = mr; ex_branch_taken = br; mem_access = ma;
        imem_ready = ir; dmem_ready = dr; clear_count = clr;
        e.name = nm; e.outs = eo; e.st = es; e.cnt = 16'(ec); e.cnt2 = 2'(ec2);
        q.push_back(e);
    endtask

    task automatic idle(input string nm, input logic [4:0] eo, input logic [1:0] es,
                        input int ec, input int ec2);
        drive(nm, 1'b1, 5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 1, 0, eo, es, ec, ec2);
    endtask

    initial begin : monitor
        exp_t e;
        logic [4:0] a, a2;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e  = q.pop_front();
                a  = {pc_en, if_id_en, ex_mem_en, if_id_flush, id_ex_flush};
                a2 = {pc_en2, if_id_en2, ex_mem_en2, if_id_flush2, id_ex_flush2};
                n_total++;
                if (a === e.outs && a2 === e.outs && state === e.st && state2 === e.st &&
                    stall_count === e.cnt && stall_count2 === e.cnt2) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got outs=%b/%b state=%0d/%0d cnt=%0d cnt2=%0d, want outs=%b state=%0d cnt=%0d cnt2=%0d",
                             e.name, a, a2, state, state2, stall_count, stall_count2,
                             e.outs, e.st, e.cnt, e.cnt2);
                end
            end
        end
    end

    initial begin : driver
        reset = 1'b0; id_rs1 = 5'd1; id_rs2 = 5'd2; ex_rd = 5'd3;
        ex_mem_read = 0; ex_branch_taken = 0; mem_access = 0;
        imem_ready = 1; dmem_ready = 1; clear_count = 0;

        drive("reset", 0, 1, 2, 3, 0, 0, 0, 1, 1, 0, O_RST, 0, 0, 0);
        idle("idle", O_DEF, 0, 0, 0);
        // load-use on rs2
        drive("lu", 1, 5'd1, 5'd5, 5'd5, 1, 0, 0, 1, 1, 0, O_LU, 0, 0, 0);
        drive("lu_hold", 1, 5'd1, 5'd5, 5'd5, 1, 0, 0, 1, 1, 0, O_DEF, 1, 1, 1);
        idle("lu_done", O_DEF, 0, 1, 1);
        idle("clr1", O_DEF, 0, 1, 1);
        drive("clr1b", 1, 1, 2, 3, 0, 0, 0, 1, 1, 1, O_DEF, 0, 1, 1);
        // zero register never interlocks
        drive("zero", 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 1, 1, 0, O_DEF, 0, 0, 0);
        idle("zero_after", O_DEF, 0, 0, 0);
        // data-memory wait for three cycles
        drive("dw1", 1, 1, 2, 3, 0, 0, 1, 1, 0, 0, O_DST, 0, 0, 0);
        drive("dw2", 1, 1, 2, 3, 0, 0, 1, 1, 0, 0, O_DST, 2, 1, 1);
        drive("dw3", 1, 1, 2, 3, 0, 0, 1, 1, 0, 0, O_DST, 2, 2, 2);
        drive("dw_rdy", 1, 1, 2, 3, 0, 0, 1, 1, 1, 0, O_DEF, 2, 3, 3);
        idle("dw_done", O_DEF, 0, 3, 3);
        drive("clr2", 1, 1, 2, 3, 0, 0, 0, 1, 1, 1, O_DEF, 0, 3, 3);
        // branch beats load-use, dstall beats branch
        drive("br_lu", 1, 5'd1, 5'd5, 5'd5, 1, 1, 0, 1, 1, 0, O_BR, 0, 0, 0);
        idle("redir", O_RD, 3, 0, 0);
        drive("br_dst", 1, 5'd1, 5'd5, 5'd5, 1, 1, 1, 1, 0, 0, O_DST, 0, 0, 0);
        idle("mw_rel", O_DEF, 2, 1, 1);
        drive("br2", 1, 1, 2, 3, 0, 1, 0, 1, 1, 0, O_BR, 0, 1, 1);
        drive("redir_dst", 1, 1, 2, 3, 0, 1, 1, 1, 0, 0, O_DST, 3, 1, 1);
        drive("redir_imem", 1, 1, 2, 3, 0, 0, 0, 0, 1, 0, O_IM, 3, 2, 2);
        drive("imem_wait", 1, 1, 2, 3, 0, 0, 0, 0, 1, 0, O_IM, 0, 3, 3);
        idle("imem_ok", O_DEF, 0, 4, 3);
        // clear wins over a simultaneous stall
        drive("clr_stall", 1, 1, 2, 3, 0, 0, 1, 1, 0, 1, O_DST, 0, 4, 3);
        idle("clr_after", O_DEF, 2, 0, 0);
        // five stall cycles saturate the 2-bit counter
        for (int i = 0; i < 5; i++)
            drive($sformatf("im%0d", i), 1, 1, 2, 3, 0, 0, 0, 0, 1, 0, O_IM, 0, i, (i > 3) ? 3 : i);
        idle("im_end", O_DEF, 0, 5, 3);
        // load-use on rs1, then dstall out of LOAD_STALL
        drive("lu2", 1, 5'd7, 5'd2, 5'd7, 1, 0, 0, 1, 1, 0, O_LU, 0, 5, 3);
        drive("ls_dst", 1, 5'd7, 5'd2, 5'd7, 1, 0, 1, 1, 0, 0, O_DST, 1, 6, 3);
        idle("ls_ready", O_DEF, 2, 7, 3);
        // reset in MEM_WAIT
        drive("mw1", 1, 1, 2, 3, 0, 0, 1, 1, 0, 0, O_DST, 0, 7, 3);
        drive("mw2", 1, 1, 2, 3, 0, 0, 1, 1, 0, 0, O_DST, 2, 8, 3);
        drive("rst_mw", 0, 1, 2, 3, 0, 0, 1, 1, 0, 0, O_RST, 0, 0, 0);
        idle("rst_rel", O_DEF, 0, 0, 0);
        idle("post", O_DEF, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
        if (q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
